// File: rtl/sdram_stream_pkg.sv
// sdram_stream_pkg: shared state type, default widths and read-credit helper for sdram_stream_reader.
package sdram_stream_pkg;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_LEN_W      = 24;
    localparam int DEF_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    // Every in-flight read already owns a FIFO slot, so a new read may only issue while slots remain.
    function automatic logic has_credit(input int outstanding, input int fifo_count, input int depth);
        return (outstanding + fifo_count) < depth;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO with occupancy count; head reads as zero while empty.
module sync_fifo #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16,
    localparam int AW        = $clog2(FIFO_DEPTH),
    localparam int CW        = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic [CW-1:0]     count
);
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;

    assign empty = count == '0;
    assign dout  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (!(push && count == CW'(FIFO_DEPTH)));
    end
endmodule

// File: rtl/sdram_stream_reader.sv
// sdram_stream_reader: Avalon-MM read master streaming a block of SDRAM words out as Avalon-ST.
// Define STREAM_CHECKSUM_EN to add a checksum output summing every delivered word.
module sdram_stream_reader
    import sdram_stream_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_endofpacket
`ifdef STREAM_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t            state, next_state;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len, issued, popped;
    logic [CW-1:0]     outstanding, fifo_count;
    logic              start_ok, credit, accept, resp, pop, empty;

    assign start_ok       = start && state == IDLE;
    assign credit         = has_credit(int'(outstanding), int'(fifo_count), FIFO_DEPTH);
    assign avm_read       = state == READ && credit;
    assign avm_address    = addr;
    assign accept         = avm_read && !avm_waitrequest;
    // Responses outside a transfer belong to an aborted one and are dropped.
    assign resp           = avm_readdatavalid && state != IDLE;
    assign st_valid       = !empty;
    assign pop            = st_valid && st_ready;
    assign st_endofpacket = st_valid && popped == len - LEN_W'(1);
    assign busy           = state == READ || state == DRAIN;
    assign done           = state == DONE;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) state <= IDLE;
        else state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = word_count == '0 ? DONE : READ;
            READ:    if (accept && issued + LEN_W'(1) == len) next_state = DRAIN;
            DRAIN:   if (outstanding == '0 && empty && popped == len) next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            addr        <= '0;
            len         <= '0;
            issued      <= '0;
            popped      <= '0;
            outstanding <= '0;
        end else begin
            if (start_ok) begin
                addr   <= {base_addr[ADDR_W-1:1], 1'b0};
                len    <= word_count;
                issued <= '0;
                popped <= '0;
            end else begin
                if (accept) begin
                    addr   <= addr + ADDR_W'(2);
                    issued <= issued + LEN_W'(1);
                end
                if (pop) popped <= popped + LEN_W'(1);
            end
            outstanding <= outstanding + CW'(accept) - CW'(resp);
        end
    end

    sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk_clk),
        .rst   (reset_reset),
        .push  (resp),
        .din   (avm_readdata),
        .pop   (pop),
        .dout  (st_data),
        .empty (empty),
        .count (fifo_count)
    );

`ifdef STREAM_CHECKSUM_EN
    always_ff @(posedge clk_clk) begin
        if (reset_reset || start_ok) checksum <= '0;
        else if (pop) checksum <= checksum + st_data;
    end
`endif
endmodule

// File: tb/tb_sdram_stream_reader.sv
// tb_sdram_stream_reader: randomized bench with an SDRAM slave model and an expected-stream reference.
module tb_sdram_stream_reader;
    localparam int D = 16;

    logic        clk_clk = 0, reset_reset = 1, start = 0;
    logic [31:0] base_addr = 0;
    logic [23:0] word_count = 0;
    logic        busy, done, avm_read, st_valid, st_endofpacket;
    logic [31:0] avm_address;
    logic        avm_waitrequest = 0, avm_readdatavalid = 0, st_ready = 0;
    logic [15:0] avm_readdata = 0, st_data;
`ifdef STREAM_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    sdram_stream_reader dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .start(start), .base_addr(base_addr),
        .word_count(word_count), .busy(busy), .done(done), .avm_address(avm_address),
        .avm_read(avm_read), .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .st_data(st_data), .st_valid(st_valid),
        .st_ready(st_ready), .st_endofpacket(st_endofpacket)
`ifdef STREAM_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk_clk = ~clk_clk;

    int vectors = 0, miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model: overrides first, otherwise a salted address pattern.
    logic [15:0] mem_ovr [logic [31:0]];
    logic [15:0] salt = 0;
    function automatic logic [15:0] mem_word(input logic [31:0] a);
        return mem_ovr.exists(a) ? mem_ovr[a] : a[16:1] + salt;
    endfunction

    int cyc = 0;
    always @(posedge clk_clk) cyc <= cyc + 1;

    int          wait_mode = 0, lat_max = 1, ready_mode = 0, ready_hold = 0;
    int          pend_due[$], last_due = 0;
    logic [15:0] pend_data[$];
    logic [15:0] exp_q[$];
    logic [31:0] exp_addr = 0, prev_addr = 0;
    logic [15:0] sum_model = 0;
    int          accepts = 0, pops = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
    int          stab_err = 0, credit_err = 0, acc_at_release = -1;
    logic        prev_stall = 0, any_read = 0, busy_seen = 0, inject_late = 0;

    // Slave model and stream monitor; inputs change on the falling edge, DUT outputs are sampled there too.
    always @(negedge clk_clk) begin
        if (reset_reset) begin
            pend_due.delete();
            pend_data.delete();
            avm_readdatavalid = 0;
            avm_waitrequest   = 0;
            prev_stall        = 0;
        end else begin
            st_ready = ready_hold > 0 ? 1'b0 : (ready_mode != 0 ? 1'($urandom_range(0, 1)) : 1'b1);
            if (ready_hold > 0) begin
                ready_hold--;
                if (ready_hold == 0) acc_at_release = accepts;
            end
            if (st_valid && st_ready) begin
                if (exp_q.size() == 0) check("extra_word", 32'(st_data), 32'hFFFF_FFFF);
                else begin
                    check("st_data", 32'(st_data), 32'(exp_q[0]));
                    check("st_endofpacket", 32'(st_endofpacket), 32'(exp_q.size() == 1));
                    sum_model += st_data;
                    void'(exp_q.pop_front());
                    pops++;
                end
            end
            if (prev_stall && (!avm_read || avm_address !== prev_addr)) stab_err++;
            avm_waitrequest = wait_mode == 1 ? ~avm_waitrequest :
                              wait_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
            if (avm_read) begin
                any_read = 1;
                if (!avm_waitrequest) begin
                    int due;
                    check("avm_address", avm_address, exp_addr);
                    exp_addr += 2;
                    accepts++;
                    due = cyc + int'($urandom_range(1, lat_max));
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    pend_due.push_back(due);
                    pend_data.push_back(mem_word(avm_address));
                end
            end
            prev_stall = avm_read && avm_waitrequest;
            prev_addr  = avm_address;
            if (inject_late) begin
                avm_readdatavalid = 1;
                avm_readdata      = 16'hDEAD;
                inject_late       = 0;
            end else if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
                avm_readdatavalid = 1;
                avm_readdata      = pend_data.pop_front();
                void'(pend_due.pop_front());
            end else avm_readdatavalid = 0;
            if (accepts - pops > D) credit_err++;
            if (busy) busy_seen = 1;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic begin_xfer(input logic [31:0] base, input int count, input int hold);
        exp_q.delete();
        for (int i = 0; i < count; i++) exp_q.push_back(mem_word((base & ~32'h1) + 32'(2 * i)));
        exp_addr = base & ~32'h1;
        {done_cnt, accepts, pops, stab_err, credit_err} = '0;
        {any_read, busy_seen} = '0;
        sum_model = 0;
        acc_at_release = -1;
        ready_hold = hold;
        @(negedge clk_clk);
        start      = 1;
        base_addr  = base;
        word_count = 24'(count);
        start_cyc  = cyc;
        @(negedge clk_clk);
        start = 0;
    endtask

    task automatic finish_xfer(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 5000) begin
            @(negedge clk_clk);
            n++;
        end
        check({tag, ":done_seen"}, 32'(done_cnt != 0), 1);
        repeat (3) @(negedge clk_clk);
        check({tag, ":done_once"}, done_cnt, 1);
        check({tag, ":words_left"}, exp_q.size(), 0);
        check({tag, ":addr_stable"}, stab_err, 0);
        check({tag, ":credit"}, credit_err, 0);
        check({tag, ":busy_after"}, 32'(busy), 0);
`ifdef STREAM_CHECKSUM_EN
        check({tag, ":checksum"}, 32'(checksum), 32'(sum_model));
`endif
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ":avm_read"}, 32'(avm_read), 0);
        check({tag, ":busy"}, 32'(busy), 0);
        check({tag, ":done"}, 32'(done), 0);
        check({tag, ":st_valid"}, 32'(st_valid), 0);
        check({tag, ":st_eop"}, 32'(st_endofpacket), 0);
        check({tag, ":st_data"}, 32'(st_data), 0);
        check({tag, ":avm_address"}, avm_address, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk_clk);
        check_quiet("reset");
        reset_reset = 0;
        repeat (2) @(negedge clk_clk);

        salt = 16'h0F80;
        begin_xfer(32'h100, 8, 0);
        finish_xfer("basic");

        begin_xfer(32'h200, 0, 0);
        finish_xfer("zero");
        check("zero:no_read", 32'(any_read), 0);
        check("zero:no_busy", 32'(busy_seen), 0);
        check("zero:done_latency", 32'(done_cyc - start_cyc >= 1 && done_cyc - start_cyc <= 2), 1);

        salt = 16'h3000;
        lat_max = 3;
        begin_xfer(32'h400, 40, 30);
        finish_xfer("backpressure");
        check("backpressure:stall_at_credit", acc_at_release, D);

        wait_mode = 1;
        lat_max = 7;
        ready_mode = 1;
        begin_xfer(32'h601, 25, 0);
        finish_xfer("waitreq");

        wait_mode = 0;
        lat_max = 4;
        begin_xfer(32'h500, 20, 0);
        begin
            int n = 0;
            while (pops < 5 && n < 2000) begin
                @(negedge clk_clk);
                n++;
            end
        end
        check("abort:reached_word5", 32'(pops >= 5), 1);
        reset_reset = 1;
        exp_q.delete();
        repeat (2) @(negedge clk_clk);
        check_quiet("abort");
        reset_reset = 0;
        inject_late = 1;
        repeat (4) @(negedge clk_clk);
        check("abort:late_dropped", 32'(st_valid), 0);
        check("abort:no_done", done_cnt, 0);
        begin_xfer(32'h300, 3, 0);
        finish_xfer("after_abort");

        ready_mode = 0;
        begin_xfer(32'hFFFF_FFF8, 10, 0);
        finish_xfer("addr_wrap");

`ifdef STREAM_CHECKSUM_EN
        mem_ovr[32'h2000] = 16'hFFFF;
        mem_ovr[32'h2002] = 16'h0002;
        mem_ovr[32'h2004] = 16'h0010;
        begin_xfer(32'h2000, 3, 0);
        finish_xfer("csum");
        check("csum:value", 32'(checksum), 32'h0011);
`endif

        for (int t = 0; t < 6; t++) begin
            salt       = 16'($urandom);
            wait_mode  = int'($urandom_range(0, 2));
            lat_max    = int'($urandom_range(1, 7));
            ready_mode = 1;
            begin_xfer($urandom, int'($urandom_range(1, 50)), int'($urandom_range(0, 20)));
            finish_xfer($sformatf("rand%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
